// File: rtl/param_processor.sv
// Multi-cycle register-file processor: mv, mvi and five ALU ops over one shared bus.
// Define PROC_ZFLAG_EN to add the Z flag and the mvnz instruction (opcode 110).
module param_processor #(
    parameter int W = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Run,
    input  logic [W-1:0] DIN,
    output logic [W-1:0] Bus,
    output logic         Done,
    output logic         Busy
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    state_t         state_q, state_d;
    logic [W-1:0]   regs_q [8];
    logic [W-1:0]   a_q;
    logic [W-1:0]   g_q;
    logic [8:0]     ir_q;
`ifdef PROC_ZFLAG_EN
    logic           z_q;
`endif

    logic [2:0]     op;
    logic [2:0]     rx;
    logic [2:0]     ry;
    logic           is_alu;
    logic [W-1:0]   bus_d;
    logic [W-1:0]   alu_res;
    logic           done_d;
    logic           ir_we;
    logic           rx_we;
    logic           a_we;
    logic           g_we;

    assign op = ir_q[8:6];
    assign rx = ir_q[5:3];
    assign ry = ir_q[2:0];

    assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                    (op == OP_OR)  || (op == OP_XOR);

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a_q + bus_d;
            OP_SUB:  alu_res = a_q - bus_d;
            OP_AND:  alu_res = a_q & bus_d;
            OP_OR:   alu_res = a_q | bus_d;
            OP_XOR:  alu_res = a_q ^ bus_d;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        bus_d   = '0;
        done_d  = 1'b0;
        ir_we   = 1'b0;
        rx_we   = 1'b0;
        a_we    = 1'b0;
        g_we    = 1'b0;
        unique case (state_q)
            T0: begin
                if (Run) begin
                    ir_we   = 1'b1;
                    state_d = T1;
                end
            end
            T1: begin
                if (is_alu) begin
                    bus_d   = regs_q[rx];
                    a_we    = 1'b1;
                    state_d = T2;
                end else begin
                    done_d  = 1'b1;
                    state_d = T0;
                    case (op)
                        OP_MV: begin
                            bus_d = regs_q[ry];
                            rx_we = 1'b1;
                        end
                        OP_MVI: begin
                            bus_d = DIN;
                            rx_we = 1'b1;
                        end
`ifdef PROC_ZFLAG_EN
                        OP_MVNZ: begin
                            if (!z_q) begin
                                bus_d = regs_q[ry];
                                rx_we = 1'b1;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
            T2: begin
                bus_d   = regs_q[ry];
                g_we    = 1'b1;
                state_d = T3;
            end
            T3: begin
                bus_d   = g_q;
                rx_we   = 1'b1;
                done_d  = 1'b1;
                state_d = T0;
            end
        endcase
    end

    // A reset cycle aborts the instruction, so its Done is suppressed too.
    assign Bus  = bus_d;
    assign Done = done_d & ~Reset;
    assign Busy = (state_q != T0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= T0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            a_q  <= '0;
            g_q  <= '0;
            ir_q <= '0;
`ifdef PROC_ZFLAG_EN
            z_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (ir_we) begin
                ir_q <= DIN[8:0];
            end
            if (rx_we) begin
                regs_q[rx] <= bus_d;
            end
            if (a_we) begin
                a_q <= bus_d;
            end
            if (g_we) begin
                g_q <= alu_res;
`ifdef PROC_ZFLAG_EN
                z_q <= (alu_res == '0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_param_processor.sv
// Scoreboard bench for param_processor: per-cycle Bus/Done/Busy expectations
// from an instruction-level reference model, checked by an independent monitor.
module tb_param_processor;

    localparam int W = 16;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Run;
    logic [W-1:0] DIN;
    logic [W-1:0] Bus;
    logic         Done;
    logic         Busy;

    param_processor #(.W(W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Run   (Run),
        .DIN   (DIN),
        .Bus   (Bus),
        .Done  (Done),
        .Busy  (Busy)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [W-1:0] bus;
        logic         done;
        logic         busy;
        int           id;
    } exp_t;

    exp_t         exp_q[$];
    int           tests = 0;
    int           fails = 0;
    int           push_id = 0;
    bit           stim_done = 0;

    logic [W-1:0] m_r [8];
    bit           m_z;

    localparam logic [2:0] MV = 3'b000, MVI = 3'b001, ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b011, AND_ = 3'b100, OR_ = 3'b101;
    localparam logic [2:0] MVNZ = 3'b110, XOR_ = 3'b111;

    // Monitor: pops one expectation per cycle, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (Bus !== e.bus || Done !== e.done || Busy !== e.busy) begin
                    fails++;
                    $display("FAIL cycle#%0d: got bus=%h done=%b busy=%b, want bus=%h done=%b busy=%b",
                             e.id, Bus, Done, Busy, e.bus, e.done, e.busy);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step(input logic r, input logic [W-1:0] d, input logic rst,
                        input logic [W-1:0] eb, input logic ed, input logic ey);
        @(posedge Clock);
        #1;
        Run   = r;
        DIN   = d;
        Reset = rst;
        exp_q.push_back('{bus: eb, done: ed, busy: ey, id: push_id});
        push_id++;
    endtask

    function automatic logic [W-1:0] alu(input logic [2:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            AND_:    return a & b;
            OR_:     return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic bit is_alu(input logic [2:0] op);
        return op inside {ADD, SUB, AND_, OR_, XOR_};
    endfunction

    function automatic logic [W-1:0] fetch_word(input logic [2:0] op,
                                                input logic [2:0] x,
                                                input logic [2:0] y);
        logic [W-1:0] d;
        d      = W'($urandom);
        d[8:0] = {op, x, y};
        return d;
    endfunction

    function automatic logic noise_run(input bit hold);
        return hold ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    // One full instruction, T0 fetch through Done.
    task automatic exec(input logic [2:0] op, input logic [2:0] x,
                        input logic [2:0] y, input logic [W-1:0] imm,
                        input bit hold);
        logic [W-1:0] res;
        step(1'b1, fetch_word(op, x, y), 1'b0, '0, 1'b0, 1'b0);
        if (is_alu(op)) begin
            res = alu(op, m_r[x], m_r[y]);
            step(noise_run(hold), W'($urandom), 1'b0, m_r[x], 1'b0, 1'b1);
            step(noise_run(hold), W'($urandom), 1'b0, m_r[y], 1'b0, 1'b1);
            step(noise_run(hold), W'($urandom), 1'b0, res, 1'b1, 1'b1);
            m_r[x] = res;
            m_z    = (res == '0);
        end else if (op == MV) begin
            step(noise_run(hold), W'($urandom), 1'b0, m_r[y], 1'b1, 1'b1);
            m_r[x] = m_r[y];
        end else if (op == MVI) begin
            step(noise_run(hold), imm, 1'b0, imm, 1'b1, 1'b1);
            m_r[x] = imm;
        end else begin
`ifdef PROC_ZFLAG_EN
            if (!m_z) begin
                step(noise_run(hold), W'($urandom), 1'b0, m_r[y], 1'b1, 1'b1);
                m_r[x] = m_r[y];
            end else begin
                step(noise_run(hold), W'($urandom), 1'b0, '0, 1'b1, 1'b1);
            end
`else
            step(noise_run(hold), W'($urandom), 1'b0, '0, 1'b1, 1'b1);
`endif
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_z = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, W'($urandom), 1'b0, '0, 1'b0, 1'b0);
        end
    endtask

    task automatic show(input logic [2:0] r);
        exec(MV, 3'd7, r, '0, 1'b0);
    endtask

    initial begin
        logic [2:0] ops[5];
        ops = '{AND_, OR_, XOR_, ADD, SUB};
        Reset = 1'b1;
        Run   = 1'b0;
        DIN   = '0;
        model_reset();
        @(posedge Clock);
        #1;
        step(1'b1, '0, 1'b1, '0, 1'b0, 1'b0);
        idle(2);

        exec(MVI, 3'd0, 3'd0, 16'h0005, 1'b0);
        exec(MV, 3'd1, 3'd0, '0, 1'b0);
        show(3'd1);

        exec(MVI, 3'd0, 3'd0, 16'hFFFF, 1'b0);
        exec(MVI, 3'd1, 3'd0, 16'h0002, 1'b0);
        exec(ADD, 3'd0, 3'd1, '0, 1'b0);
        show(3'd0);

        exec(MVI, 3'd2, 3'd0, 16'h1234, 1'b0);
        exec(MVI, 3'd3, 3'd0, 16'h1234, 1'b0);
        exec(MVI, 3'd4, 3'd0, 16'hBEEF, 1'b0);
        exec(SUB, 3'd2, 3'd3, '0, 1'b0);
        exec(MVNZ, 3'd4, 3'd3, '0, 1'b0);
        show(3'd4);
        show(3'd2);

        exec(MVI, 3'd2, 3'd0, 16'h0003, 1'b0);
        exec(ADD, 3'd2, 3'd2, '0, 1'b0);
        exec(MVNZ, 3'd5, 3'd2, '0, 1'b0);
        show(3'd5);

        for (int i = 0; i < 3; i++) begin
            exec(MVI, 3'd5, 3'd0, 16'h00F0, 1'b0);
            exec(MVI, 3'd6, 3'd0, 16'h0FF0, 1'b0);
            exec(ops[i], 3'd5, 3'd6, '0, 1'b0);
            show(3'd5);
        end

        exec(MVI, 3'd1, 3'd0, 16'h1111, 1'b0);
        exec(MVI, 3'd2, 3'd0, 16'h2222, 1'b0);
        step(1'b1, fetch_word(ADD, 3'd1, 3'd2), 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, W'($urandom), 1'b0, m_r[1], 1'b0, 1'b1);
        step(1'b1, W'($urandom), 1'b1, m_r[2], 1'b0, 1'b1);
        model_reset();
        step(1'b0, W'($urandom), 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) show(3'(i));

        exec(MVI, 3'd3, 3'd0, 16'h7000, 1'b1);
        exec(MVI, 3'd4, 3'd0, 16'h9001, 1'b1);
        exec(ADD, 3'd3, 3'd4, '0, 1'b1);
        exec(MV, 3'd6, 3'd3, '0, 1'b1);
        exec(SUB, 3'd6, 3'd4, '0, 1'b1);
        show(3'd6);

        for (int n = 0; n < 400; n++) begin
            logic [2:0] op;
            op = 3'($urandom);
            exec(op, 3'($urandom), 3'($urandom), W'($urandom),
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        for (int i = 0; i < 8; i++) show(3'(i));

        idle(2);
        @(posedge Clock);
        @(posedge Clock);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
